// File: rtl/xcorr_sync_ctrl.sv
// Frame-sync controller: sequences SEARCH/VERIFY/LOCK from correlator peak pulses and drives the detector threshold.
// Optional statistics counters (lock_cnt, miss_total) are enabled by defining XCORR_SYNC_STATS_EN.
module xcorr_sync_ctrl #(
  parameter int WDTH_CRR  = 24,
  parameter int FRAME_LEN = 1024,
  parameter int TOL       = 4,
  parameter int N_CONFIRM = 3,
  parameter int N_MISS    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                peak_sop,
  input  logic [WDTH_CRR-1:0] thr_search,
  input  logic [WDTH_CRR-1:0] thr_track,
  output logic [WDTH_CRR-1:0] thr_lvl,
  output logic [1:0]          state,
  output logic                lock,
  output logic                frame_start,
  output logic                miss_err
`ifdef XCORR_SYNC_STATS_EN
  ,
  output logic [15:0]         lock_cnt,
  output logic [15:0]         miss_total
`endif
);

  localparam int DW = $clog2(FRAME_LEN + TOL + 2);
  localparam int CW = $clog2(N_CONFIRM + 1);
  localparam int MW = $clog2(N_MISS + 1);

  localparam logic [DW-1:0] D_ONE = DW'(1);
  localparam logic [DW-1:0] D_LO  = DW'(FRAME_LEN - TOL);
  localparam logic [DW-1:0] D_HI  = DW'(FRAME_LEN + TOL);
  localparam logic [DW-1:0] D_MAX = DW'(FRAME_LEN + TOL + 1);
  localparam logic [DW-1:0] D_FLY = DW'(TOL + 1);
  localparam logic [CW-1:0] CONF_LAST = CW'(N_CONFIRM - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(N_MISS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_VERIFY = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         dist_q, dist_d;
  logic [CW-1:0]         conf_q, conf_d;
  logic [MW-1:0]         miss_q, miss_d;
  logic                  frame_start_d, miss_err_d, lock_d;
  logic [WDTH_CRR-1:0]   thr_d;
  logic                  win_hit, dist_expire;

  // dist_q counts cycles since the anchor cycle, so an anchor loads 1 for the following cycle.
  assign win_hit     = en && peak_sop && (dist_q >= D_LO) && (dist_q <= D_HI);
  assign dist_expire = (dist_q == D_HI) && !win_hit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_SEARCH;
        S_SEARCH: if (peak_sop) state_d = S_VERIFY;
        S_VERIFY: begin
          if (win_hit && conf_q == CONF_LAST) state_d = S_LOCK;
          else if (dist_expire)               state_d = S_SEARCH;
        end
        S_LOCK:   if (dist_expire && miss_q == MISS_LAST) state_d = S_SEARCH;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dist_d        = (dist_q == D_MAX) ? dist_q : dist_q + D_ONE;
    conf_d        = conf_q;
    miss_d        = miss_q;
    frame_start_d = 1'b0;
    miss_err_d    = 1'b0;
    if (en) begin
      case (state_q)
        S_SEARCH: begin
          if (peak_sop) begin
            dist_d = D_ONE;
            conf_d = '0;
          end
        end
        S_VERIFY: begin
          if (win_hit) begin
            dist_d = D_ONE;
            conf_d = conf_q + CW'(1);
            if (conf_q == CONF_LAST) miss_d = '0;
          end else if (peak_sop) begin
            dist_d = D_ONE;
            conf_d = '0;
          end
        end
        S_LOCK: begin
          if (win_hit) begin
            dist_d        = D_ONE;
            miss_d        = '0;
            frame_start_d = 1'b1;
          end else if (dist_expire) begin
            // Flywheel: re-anchor virtually at the expected peak position.
            dist_d     = D_FLY;
            miss_d     = miss_q + MW'(1);
            miss_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    lock_d = (state_d == S_LOCK);
    case (state_q)
      S_IDLE:  thr_d = '1;
      S_LOCK:  thr_d = thr_track;
      default: thr_d = thr_search;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dist_q      <= '0;
      conf_q      <= '0;
      miss_q      <= '0;
      thr_lvl     <= '1;
      lock        <= 1'b0;
      frame_start <= 1'b0;
      miss_err    <= 1'b0;
    end else begin
      dist_q      <= dist_d;
      conf_q      <= conf_d;
      miss_q      <= miss_d;
      thr_lvl     <= thr_d;
      lock        <= lock_d;
      frame_start <= frame_start_d;
      miss_err    <= miss_err_d;
    end
  end

  assign state = state_q;

`ifdef XCORR_SYNC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt   <= '0;
      miss_total <= '0;
    end else begin
      if (state_q == S_VERIFY && state_d == S_LOCK && lock_cnt != 16'hFFFF)
        lock_cnt <= lock_cnt + 16'd1;
      if (miss_err_d && miss_total != 16'hFFFF)
        miss_total <= miss_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xcorr_sync_ctrl.sv
// Self-checking bench for xcorr_sync_ctrl: table of peak-timing events plus hand-written reset sequences.
// Event vectors: optional idle gap, one event cycle, then outputs compared one cycle later.
module tb_xcorr_sync_ctrl;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst, en, peak_sop;
  logic [W-1:0] thr_search, thr_track, thr_lvl;
  logic [1:0]   state;
  logic         lock, frame_start, miss_err;
`ifdef XCORR_SYNC_STATS_EN
  logic [15:0]  lock_cnt, miss_total;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  xcorr_sync_ctrl #(
    .WDTH_CRR (W),
    .FRAME_LEN(64),
    .TOL      (2),
    .N_CONFIRM(3),
    .N_MISS   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .peak_sop   (peak_sop),
    .thr_search (thr_search),
    .thr_track  (thr_track),
    .thr_lvl    (thr_lvl),
    .state      (state),
    .lock       (lock),
    .frame_start(frame_start),
    .miss_err   (miss_err)
`ifdef XCORR_SYNC_STATS_EN
    ,
    .lock_cnt   (lock_cnt),
    .miss_total (miss_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           en;
    int           gap;   // event lands gap cycles after the previous event
    bit           peak;
    logic [1:0]   st;
    bit           lk;
    bit           fs;
    bit           me;
    logic [W-1:0] thr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit e, input int g, input bit p, input logic [1:0] s,
                     input bit l, input bit f, input bit m, input logic [W-1:0] t);
    vec_t v;
    v.en = e; v.gap = g; v.peak = p; v.st = s; v.lk = l; v.fs = f; v.me = m; v.thr = t;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] s, input bit l,
                            input bit f, input bit m, input logic [W-1:0] t);
    check({tag, ".state"},       32'(state),       32'(s));
    check({tag, ".lock"},        32'(lock),        32'(l));
    check({tag, ".frame_start"}, 32'(frame_start), 32'(f));
    check({tag, ".miss_err"},    32'(miss_err),    32'(m));
    check({tag, ".thr_lvl"},     32'(thr_lvl),     32'(t));
  endtask

  localparam logic [W-1:0] T_ONES = 24'hFFFFFF;
  localparam logic [W-1:0] T_SRCH = 24'd1000;
  localparam logic [W-1:0] T_TRK  = 24'd600;

  initial begin
    rst = 1'b1; en = 1'b0; peak_sop = 1'b0;
    thr_search = T_SRCH; thr_track = T_TRK;

    //            en gap pk st    lk fs me thr
    add(1'b1,  1, 1'b0, 2'd1, 0, 0, 0, T_ONES); // 0  IDLE -> SEARCH
    add(1'b1,  1, 1'b1, 2'd2, 0, 0, 0, T_SRCH); // 1  first peak t0 -> VERIFY
    add(1'b1, 64, 1'b1, 2'd2, 0, 0, 0, T_SRCH); // 2  confirm 1
    add(1'b1, 64, 1'b1, 2'd2, 0, 0, 0, T_SRCH); // 3  confirm 2
    add(1'b1, 64, 1'b1, 2'd3, 1, 0, 0, T_SRCH); // 4  confirm 3 -> LOCK at t0+193
    add(1'b1,  1, 1'b0, 2'd3, 1, 0, 0, T_TRK ); // 5  thr_track at t0+194
    add(1'b1, 61, 1'b1, 2'd3, 1, 1, 0, T_TRK ); // 6  peak at +62 accepted
    add(1'b1, 66, 1'b1, 2'd3, 1, 1, 0, T_TRK ); // 7  peak at +66 accepted
    add(1'b1, 61, 1'b1, 2'd3, 1, 0, 0, T_TRK ); // 8  peak at +61 ignored
    add(1'b1,  3, 1'b1, 2'd3, 1, 1, 0, T_TRK ); // 9  +64 from old anchor: no re-anchor
    add(1'b1, 66, 1'b0, 2'd3, 1, 0, 1, T_TRK ); // 10 missed peak, miss_err at anchor+67
    add(1'b1,  1, 1'b0, 2'd3, 1, 0, 0, T_TRK ); // 11 miss_err single cycle
    add(1'b1, 61, 1'b1, 2'd3, 1, 1, 0, T_TRK ); // 12 peak at +128 from old anchor accepted
    add(1'b1, 66, 1'b0, 2'd3, 1, 0, 1, T_TRK ); // 13 first of two misses
    add(1'b1, 64, 1'b0, 2'd1, 0, 0, 1, T_TRK ); // 14 second miss -> SEARCH
    add(1'b1,  1, 1'b0, 2'd1, 0, 0, 0, T_SRCH); // 15 thr back to search
    add(1'b1,  1, 1'b1, 2'd2, 0, 0, 0, T_SRCH); // 16 VERIFY
    add(1'b1, 65, 1'b0, 2'd2, 0, 0, 0, T_SRCH); // 17 still VERIFY at dist 65
    add(1'b1,  1, 1'b0, 2'd1, 0, 0, 0, T_SRCH); // 18 timeout -> SEARCH 67 cycles after anchor
    add(1'b1,  1, 1'b1, 2'd2, 0, 0, 0, T_SRCH); // 19 reacquire
    add(1'b1, 64, 1'b1, 2'd2, 0, 0, 0, T_SRCH); // 20
    add(1'b1, 64, 1'b1, 2'd2, 0, 0, 0, T_SRCH); // 21
    add(1'b1, 64, 1'b1, 2'd3, 1, 0, 0, T_SRCH); // 22 second LOCK
    add(1'b0,  1, 1'b0, 2'd0, 0, 0, 0, T_TRK ); // 23 en=0 in LOCK -> IDLE next cycle
    add(1'b0,  1, 1'b0, 2'd0, 0, 0, 0, T_ONES); // 24 IDLE threshold
    add(1'b0,  1, 1'b1, 2'd0, 0, 0, 0, T_ONES); // 25 peak ignored while disabled

    repeat (3) tick();
    check_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, T_ONES);
    rst = 1'b0;
    tick();
    check_outs("post_reset_idle", 2'd0, 1'b0, 1'b0, 1'b0, T_ONES);

    foreach (vecs[i]) begin
      en = vecs[i].en;
      for (int k = 0; k < vecs[i].gap - 1; k++) begin
        peak_sop = 1'b0;
        tick();
      end
      peak_sop = vecs[i].peak;
      tick();
      peak_sop = 1'b0;
      check_outs($sformatf("v%0d", i), vecs[i].st, vecs[i].lk, vecs[i].fs, vecs[i].me, vecs[i].thr);
    end

`ifdef XCORR_SYNC_STATS_EN
    check("stats.lock_cnt",   32'(lock_cnt),   32'd2);
    check("stats.miss_total", 32'(miss_total), 32'd3);
`endif

    // Mid-operation reset from VERIFY with en still high.
    en = 1'b1;
    tick();
    check("rst_seq.search", 32'(state), 32'd1);
    peak_sop = 1'b1;
    tick();
    peak_sop = 1'b0;
    check("rst_seq.verify", 32'(state), 32'd2);
    rst = 1'b1;
    tick();
    check_outs("rst_seq.reset", 2'd0, 1'b0, 1'b0, 1'b0, T_ONES);
`ifdef XCORR_SYNC_STATS_EN
    check("rst_seq.lock_cnt",   32'(lock_cnt),   32'd0);
    check("rst_seq.miss_total", 32'(miss_total), 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("rst_seq.resume", 32'(state), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
